// File: rtl/reg_bank.sv
// reg_bank: addressed control/status register bank with RW, hardware-mirror and sticky W1C registers.
// Optional macro REG_BANK_SHADOW_EN: reg_out is driven from a shadow copy loaded on commit.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0] HW_MASK = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_strb,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic [NUM_REGS*DATA_W-1:0] hw_data,
  input  logic [NUM_REGS-1:0]        hw_valid,
  input  logic                       commit,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_pulse,
  output logic                       irq
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0]          byteMask;
  logic [NUM_REGS*DATA_W-1:0] liveFlat;
  logic [NUM_REGS*DATA_W-1:0] nextFlat;
  logic [NUM_REGS-1:0]        w1cAny;
  logic [DATA_W-1:0]          rdMux;
  logic [DATA_W-1:0]          rdDataQ;
  logic                       rdValidQ;
  logic                       irqQ;

  always_comb begin
    byteMask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byteMask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] nxt;
    logic [DATA_W-1:0] hwVal;
    logic              wrHit;
    logic              pulseQ;

    assign hwVal = hw_data[i*DATA_W +: DATA_W];
    assign wrHit = wr_en && (wr_addr == ADDR_W'(i));

    if (W1C_MASK[i]) begin : gW1c
      // Set is applied after clear so a simultaneous set and clear leaves the bit set.
      always_comb begin
        nxt = (cur & ~(wrHit ? (wr_data & byteMask) : '0)) | (hw_valid[i] ? hwVal : '0);
      end
      assign w1cAny[i] = |cur;
    end else if (HW_MASK[i]) begin : gMirror
      always_comb begin
        nxt = cur;
        if (wrHit) begin
          nxt = (wr_data & byteMask) | ((hw_valid[i] ? hwVal : cur) & ~byteMask);
        end else if (hw_valid[i]) begin
          nxt = hwVal;
        end
      end
      assign w1cAny[i] = 1'b0;
    end else begin : gRw
      logic unusedHw;
      assign unusedHw = ^{hwVal, hw_valid[i]};
      always_comb begin
        nxt = cur;
        if (wrHit) begin
          nxt = (wr_data & byteMask) | (cur & ~byteMask);
        end
      end
      assign w1cAny[i] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cur    <= RESET_VALUES[i*DATA_W +: DATA_W];
        pulseQ <= 1'b0;
      end else begin
        cur    <= nxt;
        pulseQ <= wrHit;
      end
    end

    assign liveFlat[i*DATA_W +: DATA_W] = cur;
    assign nextFlat[i*DATA_W +: DATA_W] = nxt;
    assign wr_pulse[i] = pulseQ;
  end

  // Out-of-range read addresses match no register and read as zero.
  always_comb begin
    rdMux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
        rdMux = liveFlat[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValidQ <= 1'b0;
      rdDataQ  <= '0;
    end else begin
      rdValidQ <= rd_en;
      if (rd_en) begin
        rdDataQ <= rdMux;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irqQ <= 1'b0;
    end else begin
      irqQ <= |w1cAny;
    end
  end

  assign rd_data  = rdDataQ;
  assign rd_valid = rdValidQ;
  assign irq      = irqQ;

`ifdef REG_BANK_SHADOW_EN
  logic [NUM_REGS*DATA_W-1:0] shadowQ;

  // Loading the post-update values lets a write and commit in one cycle publish together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadowQ <= RESET_VALUES;
    end else if (commit) begin
      shadowQ <= nextFlat;
    end
  end

  assign reg_out = shadowQ;
`else
  logic unusedShadow;
  assign unusedShadow = ^{commit, nextFlat};
  assign reg_out = liveFlat;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed test of reg_bank with a read scoreboard and direct output checks.
// Define REG_BANK_SHADOW_EN to also exercise the shadow/commit path.
module tb_reg_bank;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W = 4;
  localparam logic [255:0] RESET_IMG = 256'h0000_00A5_0000_0000;
  localparam logic [7:0] HW_M = 8'h04;
  localparam logic [7:0] W1C_M = 8'h08;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   wr_strb = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_addr = '0;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic [255:0] hw_data = '0;
  logic [7:0]   hw_valid = '0;
  logic         commit = 1'b0;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;
  logic         irq;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } rdExp_t;

  rdExp_t expQ[$];
  int     testsRun = 0;
  int     testsFailed = 0;
  int     cycleCount = 0;
  logic   commitIdle;

  reg_bank #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .RESET_VALUES(RESET_IMG), .HW_MASK(HW_M), .W1C_MASK(W1C_M)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .hw_data(hw_data), .hw_valid(hw_valid), .commit(commit),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] ws, input logic re, input logic [3:0] ra,
                               input logic [31:0] rExp, input int hwIdx, input logic [31:0] hwVal,
                               input logic cm);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_en = re; rd_addr = ra;
    hw_valid = '0; hw_data = '0;
    if (hwIdx >= 0) begin
      hw_valid[hwIdx] = 1'b1;
      hw_data[hwIdx*32 +: 32] = hwVal;
    end
    commit = cm;
    if (re) expQ.push_back('{rExp, cycleCount + 1});
    @(posedge clk);
    #1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_addr = '0;
    hw_valid = '0; hw_data = '0;
    commit = commitIdle;
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest pending read, on the expected cycle.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_data %h, required no response", rd_data);
      end else begin
        rdExp_t e;
        e = expQ.pop_front();
        checkOutput("rd_data", 256'(rd_data), 256'(e.data));
        checkOutput("rd_latency", 256'(cycleCount), 256'(e.cycle));
      end
    end
  end

  initial begin
`ifdef REG_BANK_SHADOW_EN
    commitIdle = 1'b1;
`else
    commitIdle = 1'b0;
`endif
    commit = commitIdle;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_reg_out", reg_out, RESET_IMG);
    checkOutput("reset_rd_valid", 256'(rd_valid), 256'(0));
    checkOutput("reset_rd_data", 256'(rd_data), 256'(0));
    checkOutput("reset_wr_pulse", 256'(wr_pulse), 256'(0));
    checkOutput("reset_irq", 256'(irq), 256'(0));
    rst = 1'b0;

    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_00A5, -1, 0, commitIdle);
    checkOutput("post_reset_irq", 256'(irq), 256'(0));

    // RW register 0 with partial strobes, plus a same-cycle read of the old value.
    applyStimulus(1, 0, 32'h1122_3344, 4'hF, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("rw_full_write", 256'(reg_out[31:0]), 256'(32'h1122_3344));
    checkOutput("rw_pulse0", 256'(wr_pulse), 256'(8'h01));
    applyStimulus(1, 0, 32'hDEAD_BEEF, 4'b0101, 1, 0, 32'h1122_3344, -1, 0, commitIdle);
    checkOutput("rw_strobed_write", 256'(reg_out[31:0]), 256'(32'h11AD_33EF));
    checkOutput("rw_pulse1", 256'(wr_pulse), 256'(8'h01));
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h11AD_33EF, -1, 0, commitIdle);
    checkOutput("rw_pulse_single", 256'(wr_pulse), 256'(0));

    // Mirror register 2: write beats hardware on strobed bytes, hardware fills the rest.
    applyStimulus(1, 2, 32'h0000_00AA, 4'b0001, 0, 0, 0, 2, 32'h1234_5655, commitIdle);
    checkOutput("mirror_write_hw", 256'(reg_out[95:64]), 256'(32'h1234_56AA));
    checkOutput("mirror_pulse", 256'(wr_pulse), 256'(8'h04));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 32'h0000_0077, commitIdle);
    checkOutput("mirror_hw_only", 256'(reg_out[95:64]), 256'(32'h0000_0077));
    checkOutput("mirror_no_pulse", 256'(wr_pulse), 256'(0));

    applyStimulus(0, 0, 0, 0, 1, 2, 32'h0000_0077, -1, 0, commitIdle);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h11AD_33EF, -1, 0, commitIdle);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("rd_valid_drop", 256'(rd_valid), 256'(0));
    checkOutput("rd_data_hold", 256'(rd_data), 256'(32'h11AD_33EF));

    // W1C register 3: set, set-beats-clear, clear, and irq two cycles after each change.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 32'h3, commitIdle);
    checkOutput("w1c_set", 256'(reg_out[127:96]), 256'(32'h3));
    checkOutput("w1c_irq_lag", 256'(irq), 256'(0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("w1c_irq_set", 256'(irq), 256'(1));
    applyStimulus(1, 3, 32'h1, 4'hF, 0, 0, 0, 3, 32'h1, commitIdle);
    checkOutput("w1c_set_wins", 256'(reg_out[127:96]), 256'(32'h3));
    checkOutput("w1c_pulse", 256'(wr_pulse), 256'(8'h08));
    applyStimulus(1, 3, 32'h3, 4'hF, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("w1c_clear", 256'(reg_out[127:96]), 256'(0));
    checkOutput("w1c_irq_hold", 256'(irq), 256'(1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("w1c_irq_clear", 256'(irq), 256'(0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 32'h100, commitIdle);
    applyStimulus(1, 3, 32'h100, 4'b0001, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("w1c_unstrobed_keep", 256'(reg_out[127:96]), 256'(32'h100));
    checkOutput("w1c_irq_byte1", 256'(irq), 256'(1));
    applyStimulus(1, 3, 32'h100, 4'b0010, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("w1c_strobed_clear", 256'(reg_out[127:96]), 256'(0));

    // Out-of-range address 9.
    applyStimulus(0, 0, 0, 0, 1, 9, 32'h0, -1, 0, commitIdle);
    applyStimulus(1, 9, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("oor_write_image", reg_out,
                256'h0000_0000_0000_0000_0000_0077_0000_00A5_11AD_33EF);
    checkOutput("oor_no_pulse", 256'(wr_pulse), 256'(0));

    // Reset asserted while a read is pending.
    rd_en = 1'b1; rd_addr = 4'd0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_rd_valid", 256'(rd_valid), 256'(0));
    checkOutput("abort_rd_data", 256'(rd_data), 256'(0));
    checkOutput("abort_reg_out", reg_out, RESET_IMG);
    rd_en = 1'b0;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("abort_irq", 256'(irq), 256'(0));

`ifdef REG_BANK_SHADOW_EN
    commitIdle = 1'b0;
    applyStimulus(1, 0, 32'h5, 4'hF, 0, 0, 0, -1, 0, 1'b0);
    checkOutput("shadow_hold", 256'(reg_out[31:0]), 256'(0));
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h5, -1, 0, 1'b0);
    checkOutput("shadow_hold2", 256'(reg_out[31:0]), 256'(0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, 1'b1);
    checkOutput("shadow_commit", 256'(reg_out[31:0]), 256'(32'h5));
    applyStimulus(1, 1, 32'h9, 4'hF, 0, 0, 0, -1, 0, 1'b1);
    checkOutput("shadow_write_commit", 256'(reg_out[63:32]), 256'(32'h9));
`endif

    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, commitIdle);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, -1, 0, commitIdle);
    checkOutput("reads_outstanding", 256'(expQ.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
